demux4_buf: RTL and testbench

- Inverse of the team's 4:1 case-based mux: a registered 1-to-4 demultiplexer with buffering.
- A single input stream carries a data word and a 2-bit select. Each accepted word is steered into one of four per-channel FIFOs.
- Each channel drains independently through its own valid/ready port.
- It sits downstream of a shared bus and fans traffic out to four consumers that may stall independently.

---
 rtl/demux4_buf.sv | 100 ++++++++++
 tb/tb_demux4_buf.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer: each accepted word is steered by in_sel into
// one of four first-word-fall-through FIFOs that drain independently.
module demux4_buf #(
   parameter int unsigned W     = 2,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PW    = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [1:0]    in_sel,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   output logic [W-1:0]  out_data0,
   output logic [W-1:0]  out_data1,
   output logic [W-1:0]  out_data2,
   output logic [W-1:0]  out_data3,
   output logic [PW:0]   count0,
   output logic [PW:0]   count1,
   output logic [PW:0]   count2,
   output logic [PW:0]   count3
);

   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = PW + 1;

   logic [W-1:0]  mem_q    [NCH][DEPTH];
   logic [W-1:0]  mem_d    [NCH][DEPTH];
   logic [PW-1:0] wr_ptr_q [NCH];
   logic [PW-1:0] wr_ptr_d [NCH];
   logic [PW-1:0] rd_ptr_q [NCH];
   logic [PW-1:0] rd_ptr_d [NCH];
   logic [CW-1:0] cnt_q    [NCH];
   logic [CW-1:0] cnt_d    [NCH];
   logic [NCH-1:0] push;
   logic [NCH-1:0] pop;

   // Ready looks only at registered occupancy, never at out_ready.
   assign in_ready = !rst && (cnt_q[in_sel] != CW'(DEPTH));

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         out_valid[k] = (cnt_q[k] != '0);
      end
   end

   // Per-channel push/pop qualification and next-state.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      push     = '0;
      pop      = '0;
      for (int k = 0; k < NCH; k++) begin
         push[k] = in_valid && in_ready && (in_sel == 2'(k));
         pop[k]  = out_valid[k] && out_ready[k];
         if (push[k]) begin
            mem_d[k][wr_ptr_q[k]] = in_data;
            wr_ptr_d[k]           = wr_ptr_q[k] + PW'(1);
         end
         if (pop[k]) begin
            rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
         end
         cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            cnt_q[k]    <= '0;
            for (int d = 0; d < DEPTH; d++) begin
               mem_q[k][d] <= '0;
            end
         end
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Fall-through heads: storage at each read pointer.
   assign out_data0 = mem_q[0][rd_ptr_q[0]];
   assign out_data1 = mem_q[1][rd_ptr_q[1]];
   assign out_data2 = mem_q[2][rd_ptr_q[2]];
   assign out_data3 = mem_q[3][rd_ptr_q[3]];

   assign count0 = cnt_q[0];
   assign count1 = cnt_q[1];
   assign count2 = cnt_q[2];
   assign count3 = cnt_q[3];

endmodule

// File: tb/tb_demux4_buf.sv
// Bench for demux4_buf: per-channel queue model checked every cycle plus
// scenario tasks with targeted inline checks.
module tb_demux4_buf;

   localparam int unsigned W     = 2;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned PW    = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [1:0]    in_sel;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [W-1:0]  out_data0, out_data1, out_data2, out_data3;
   logic [PW:0]   count0, count1, count2, count3;

   wire  [W-1:0]  dout [4];
   wire  [PW:0]   dcnt [4];
   assign dout[0] = out_data0;
   assign dout[1] = out_data1;
   assign dout[2] = out_data2;
   assign dout[3] = out_data3;
   assign dcnt[0] = count0;
   assign dcnt[1] = count1;
   assign dcnt[2] = count2;
   assign dcnt[3] = count3;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic [W-1:0] sbq [4][$];

   always #5 clk = ~clk;

   demux4_buf #(.W(W), .DEPTH(DEPTH), .PW(PW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
      .count0(count0), .count1(count1), .count2(count2), .count3(count3)
   );

   // One clock: scoreboard compare/update at negedge, then return #1 after posedge.
   task automatic step();
      bit exp_rdy;
      @(negedge clk);
      if (mon_en) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid[k] !== (sbq[k].size() != 0)) begin
               errors++;
               $display("FAIL sb_valid ch%0d: got %b want %b", k, out_valid[k], sbq[k].size() != 0);
            end
            checks++;
            if (dcnt[k] !== 2'(sbq[k].size())) begin
               errors++;
               $display("FAIL sb_count ch%0d: got %0d want %0d", k, dcnt[k], sbq[k].size());
            end
            if (sbq[k].size() != 0) begin
               checks++;
               if (dout[k] !== sbq[k][0]) begin
                  errors++;
                  $display("FAIL sb_data ch%0d: got %b want %b", k, dout[k], sbq[k][0]);
               end
            end
         end
         exp_rdy = !rst && (sbq[in_sel].size() != DEPTH);
         checks++;
         if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL sb_in_ready sel=%0d: got %b want %b", in_sel, in_ready, exp_rdy);
         end
         if (rst) begin
            for (int k = 0; k < 4; k++) sbq[k].delete();
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (out_ready[k] && sbq[k].size() != 0) void'(sbq[k].pop_front());
            end
            if (in_valid && exp_rdy) sbq[in_sel].push_back(in_data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] sel, input logic [W-1:0] data);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = '0; out_ready = 4'b0000;
      step();
      step();
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_held sel=%0d: got %b want 0", s, in_ready);
         end
      end
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_idle sel=%0d: got %b want 1", s, in_ready);
         end
      end
      checks++;
      if (out_valid !== 4'b0000 || {count0, count1, count2, count3} !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: valid=%b counts=%0d%0d%0d%0d want 0000/0000",
                  out_valid, count0, count1, count2, count3);
      end
      mon_en = 1'b1;
      step();
   endtask

   task automatic test_steer();
      logic [W-1:0] vals [4];
      logic [3:0]   exp_v;
      vals = '{2'b00, 2'b01, 2'b11, 2'b10};
      for (int i = 0; i < 4; i++) begin
         push(2'(i), vals[i]);
         exp_v = 4'((1 << (i + 1)) - 1);
         checks++;
         if (out_valid !== exp_v) begin
            errors++;
            $display("FAIL steer_valid step%0d: got %b want %b", i, out_valid, exp_v);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dout[i] !== vals[i] || dcnt[i] !== 2'd1) begin
            errors++;
            $display("FAIL steer_head ch%0d: data=%b cnt=%0d want %b/1", i, dout[i], dcnt[i], vals[i]);
         end
      end
      out_ready = 4'b1111;
      step();
      out_ready = 4'b0000;
   endtask

   task automatic test_fill();
      push(2'b10, 2'b11);
      push(2'b10, 2'b01);
      checks++;
      if (count2 !== 2'd2) begin
         errors++;
         $display("FAIL fill_count2: got %0d want 2", count2);
      end
      in_valid = 1'b1; in_sel = 2'b10; in_data = 2'b10;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_blocks: in_ready=%b want 0", in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (count2 !== 2'd2 || out_data2 !== 2'b11) begin
         errors++;
         $display("FAIL full_refused: cnt=%0d head=%b want 2/11", count2, out_data2);
      end
      in_sel = 2'b00;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL other_sel_ready: in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_drain_wrap();
      out_ready = 4'b0100;
      step();
      checks++;
      if (count2 !== 2'd1 || out_data2 !== 2'b01) begin
         errors++;
         $display("FAIL drain1: cnt=%0d head=%b want 1/01", count2, out_data2);
      end
      step();
      checks++;
      if (count2 !== 2'd0 || out_valid[2] !== 1'b0) begin
         errors++;
         $display("FAIL drain2: cnt=%0d valid=%b want 0/0", count2, out_valid[2]);
      end
      push(2'b10, 2'b01);
      push(2'b10, 2'b10);
      push(2'b10, 2'b11);
      checks++;
      if (count2 !== 2'd1 || out_data2 !== 2'b11) begin
         errors++;
         $display("FAIL wrap_head: cnt=%0d head=%b want 1/11", count2, out_data2);
      end
      step();
      out_ready = 4'b0000;
   endtask

   task automatic test_back_to_back();
      push(2'b01, 2'b01);
      out_ready = 4'b0010;
      push(2'b01, 2'b10);
      checks++;
      if (count1 !== 2'd1 || out_data1 !== 2'b10) begin
         errors++;
         $display("FAIL pushpop_same: cnt=%0d head=%b want 1/10", count1, out_data1);
      end
      out_ready = 4'b0000;
      push(2'b01, 2'b11);
      in_valid = 1'b1; in_sel = 2'b01; in_data = 2'b00; out_ready = 4'b0010;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_pushpop_ready: in_ready=%b want 0", in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (count1 !== 2'd1 || out_data1 !== 2'b11) begin
         errors++;
         $display("FAIL full_pushpop: cnt=%0d head=%b want 1/11", count1, out_data1);
      end
      step();
      out_ready = 4'b0000;
   endtask

   task automatic test_mid_reset();
      push(2'b00, 2'b10);
      push(2'b00, 2'b01);
      push(2'b01, 2'b11);
      push(2'b11, 2'b01);
      checks++;
      if ({count0, count1, count2, count3} !== {2'd2, 2'd1, 2'd0, 2'd1}) begin
         errors++;
         $display("FAIL pre_reset_counts: got %0d%0d%0d%0d want 2101", count0, count1, count2, count3);
      end
      rst = 1'b1; in_valid = 1'b1; in_sel = 2'b10; in_data = 2'b01;
      step();
      rst = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 4'b0000 || {count0, count1, count2, count3} !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset: valid=%b counts=%0d%0d%0d%0d want 0000/0000",
                  out_valid, count0, count1, count2, count3);
      end
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_steer();
      test_fill();
      test_drain_wrap();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
